bilinear_mult_issuer: RTL and testbench

//  Initiator side of the 16-bit multiplier request/product handshake (mul_p/mul_l/mul_rdy -> prod/prod_rdy).

---
 rtl/bilinear_mult_issuer.sv | 149 ++++++++++++++
 tb/tb_bilinear_mult_issuer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_mult_issuer.sv
// Bilinear interpolation job issuer: serialises four pixel*weight products onto the shared
// 16-bit multiplier, accumulates the returned products, then rounds and saturates one output pixel.
module bilinear_mult_issuer #(
    parameter int PIX_W   = 8,
    parameter int FRAC    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*PIX_W-1:0]      pix_in,
    input  logic [4*(FRAC+1)-1:0]   wgt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        pix_out,
    output logic [15:0]             mul_p,
    output logic [15:0]             mul_l,
    output logic                    mul_rdy,
    input  logic [15:0]             prod_in,
    input  logic                    prod_in_rdy,
    output logic                    err_timeout
);

    localparam int WGT_W = FRAC + 1;
    localparam int ACC_W = PIX_W + FRAC + 3;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int HALF  = 1 << (FRAC - 1);
    localparam logic [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << PIX_W) - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROUND, OUT} state_t;

    typedef struct packed {
        logic [3:0][PIX_W-1:0] pix;
        logic [3:0][WGT_W-1:0] wgt;
    } job_t;

    state_t              state, state_d;
    job_t                job_q, job_d;
    logic [1:0]          idx, idx_d;
    logic [ACC_W-1:0]    acc, acc_d;
    logic [TMR_W-1:0]    timer, timer_d;

    logic                in_ready_d, out_valid_d, mul_rdy_d, err_d;
    logic [PIX_W-1:0]    pix_out_d;
    logic [15:0]         mul_p_d, mul_l_d;

    // Round half up, then clamp anything above the pixel range (weights may sum past 1.0).
    logic [ACC_W:0]      rnd_sum, rnd_shift;
    assign rnd_sum   = {1'b0, acc} + (ACC_W+1)'(HALF);
    assign rnd_shift = rnd_sum >> FRAC;

    always_comb begin
        state_d     = state;
        job_d       = job_q;
        idx_d       = idx;
        acc_d       = acc;
        timer_d     = timer;
        out_valid_d = out_valid;
        pix_out_d   = pix_out;
        mul_p_d     = mul_p;
        mul_l_d     = mul_l;
        mul_rdy_d   = 1'b0;
        err_d       = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    job_d     = {pix_in, wgt_in};
                    acc_d     = '0;
                    idx_d     = '0;
                    mul_p_d   = 16'(pix_in[PIX_W-1:0]);
                    mul_l_d   = 16'(wgt_in[WGT_W-1:0]);
                    mul_rdy_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (prod_in_rdy) begin
                    acc_d = acc + ACC_W'(prod_in);
                    if (idx == 2'd3) begin
                        state_d = ROUND;
                    end else begin
                        idx_d     = idx + 2'd1;
                        mul_p_d   = 16'(job_q.pix[idx_d]);
                        mul_l_d   = 16'(job_q.wgt[idx_d]);
                        mul_rdy_d = 1'b1;
                        state_d   = ISSUE;
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ROUND: begin
                pix_out_d   = (rnd_shift > PIX_MAX) ? '1 : rnd_shift[PIX_W-1:0];
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // in_ready is registered, so it rises in the first cycle spent in IDLE.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            job_q       <= '0;
            idx         <= '0;
            acc         <= '0;
            timer       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            pix_out     <= '0;
            mul_p       <= '0;
            mul_l       <= '0;
            mul_rdy     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            job_q       <= job_d;
            idx         <= idx_d;
            acc         <= acc_d;
            timer       <= timer_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            pix_out     <= pix_out_d;
            mul_p       <= mul_p_d;
            mul_l       <= mul_l_d;
            mul_rdy     <= mul_rdy_d;
            err_timeout <= err_d;
        end
    end

endmodule

// File: tb/tb_bilinear_mult_issuer.sv
// Bench for bilinear_mult_issuer: multiplier stub, scoreboard queue of expected pixels/aborts,
// and a negedge monitor that pops and compares on every output handshake or abort pulse.
module tb_bilinear_mult_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pix_in = '0;
    logic [35:0] wgt_in = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pix_out;
    logic [15:0] mul_p, mul_l;
    logic        mul_rdy;
    logic [15:0] prod_in = '0;
    logic        prod_in_rdy = 1'b0;
    logic        err_timeout;

    logic rnd_ready = 1'b0, rnd_or = 1'b1, force_or = 1'b1;
    assign out_ready = rnd_ready ? rnd_or : force_or;

    bilinear_mult_issuer #(.PIX_W(8), .FRAC(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pix_in(pix_in), .wgt_in(wgt_in), .out_valid(out_valid), .out_ready(out_ready),
        .pix_out(pix_out), .mul_p(mul_p), .mul_l(mul_l), .mul_rdy(mul_rdy),
        .prod_in(prod_in), .prod_in_rdy(prod_in_rdy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { bit to; int val; } exp_t;
    exp_t exp_q[$];
    int acc_q[$], mul_q[$], ovr_q[$], hs_q[$];
    int checks = 0, failures = 0, cyc = 0, proto_err = 0, err_cnt = 0, err_cyc = 0;
    bit stub_never = 0, rnd_lat = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial forever begin @(posedge clk); cyc++; end

    // Multiplier stub: sample operands, compute, then one-cycle product pulse.
    initial begin
        logic [15:0] a, b;
        int ex;
        @(posedge clk); #1;
        forever begin
            if (mul_rdy && !reset && !stub_never) begin
                a = mul_p; b = mul_l;
                ex = rnd_lat ? int'($urandom_range(0, 4)) : 0;
                repeat (2 + ex) begin @(posedge clk); #1; end
                prod_in = 16'(32'(a) * 32'(b));
                prod_in_rdy = 1'b1;
                @(posedge clk); #1;
                prod_in_rdy = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rnd_or = ($urandom_range(0, 3) != 0);
    end

    // Monitor / scoreboard consumer.
    initial begin
        bit outstanding = 0, mul_prev = 0, ov_prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                outstanding = 0; mul_prev = 0; ov_prev = 0;
            end else begin
                if (in_valid && in_ready) acc_q.push_back(cyc);
                if (mul_rdy) begin
                    if (outstanding || mul_prev) proto_err++;
                    outstanding = 1;
                    mul_q.push_back(cyc);
                end
                mul_prev = mul_rdy;
                if (prod_in_rdy) outstanding = 0;
                if (out_valid && !ov_prev) ovr_q.push_back(cyc);
                ov_prev = out_valid;
                if (err_timeout) begin
                    outstanding = 0; err_cnt++; err_cyc = cyc;
                    if (exp_q.size() == 0) chk("err_unexpected", 1, 0);
                    else begin e = exp_q.pop_front(); chk("err_kind", 1, int'(e.to)); end
                end
                if (out_valid && out_ready) begin
                    hs_q.push_back(cyc);
                    if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_kind", 0, int'(e.to));
                        chk("pix_out", int'(pix_out), e.val);
                    end
                end
            end
        end
    end

    // Reference: weighted sum, round half up at 2^-8, clamp to 255.
    task automatic send_job(input logic [31:0] p, input logic [35:0] w);
        int sum, r, n;
        exp_t e;
        sum = 0;
        for (int i = 0; i < 4; i++) sum += int'(p[8*i +: 8]) * int'(w[9*i +: 9]);
        r = (sum + 128) / 256;
        e.to = stub_never;
        e.val = (r > 255) ? 255 : r;
        exp_q.push_back(e);
        pix_in = p; wgt_in = w; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin tick(); n++; end
        if (n >= 300) chk("accept_bound", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin tick(); n++; end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        acc_q.delete(); mul_q.delete(); ovr_q.delete(); hs_q.delete();
    endtask

    initial begin
        int n, hold;
        tick(3);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pix_out", int'(pix_out), 0);
        chk("rst_mul_p", int'(mul_p), 0);
        chk("rst_mul_l", int'(mul_l), 0);
        chk("rst_mul_rdy", int'(mul_rdy), 0);
        chk("rst_err", int'(err_timeout), 0);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", int'(in_ready), 1);

        // Basic timing + back-to-back acceptance
        clear_logs();
        send_job({8'd40, 8'd30, 8'd20, 8'd10}, {9'd64, 9'd64, 9'd64, 9'd64});
        send_job({8'd4, 8'd3, 8'd2, 8'd1}, {9'd256, 9'd0, 9'd0, 9'd0});
        drain();
        if (acc_q.size() >= 2 && mul_q.size() >= 4 && ovr_q.size() >= 1 && hs_q.size() >= 1) begin
            for (int i = 0; i < 4; i++) chk("mul_rdy_cycle", mul_q[i] - acc_q[0], 1 + 3 * i);
            chk("out_valid_cycle", ovr_q[0] - acc_q[0], 14);
            chk("b2b_accept", acc_q[1] - hs_q[0], 1);
        end else chk("timing_logs", 0, 1);

        // Saturation and rounding boundaries
        send_job({8'd255, 8'd255, 8'd255, 8'd255}, {9'd0, 9'd0, 9'd256, 9'd256});
        send_job({8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd128});
        send_job({8'd0, 8'd0, 8'd0, 8'd1}, {9'd0, 9'd0, 9'd0, 9'd127});
        drain();

        // Output backpressure
        force_or = 1'b0;
        clear_logs();
        send_job({8'd200, 8'd100, 8'd50, 8'd25}, {9'd64, 9'd64, 9'd64, 9'd64});
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("bp_out_valid", int'(out_valid), 1);
        hold = int'(pix_out);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_pix_stable", int'(pix_out), hold);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_mul_rdy", int'(mul_rdy), 0);
        end
        force_or = 1'b1;
        tick();
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_out_valid", int'(out_valid), 0);
        drain();

        // Multiplier never answers
        clear_logs();
        stub_never = 1;
        n = err_cnt;
        send_job({8'd9, 8'd9, 8'd9, 8'd9}, {9'd64, 9'd64, 9'd64, 9'd64});
        hold = 0;
        while (err_cnt == n && hold < 60) begin tick(); hold++; end
        stub_never = 0;
        chk("timeout_seen", err_cnt - n, 1);
        if (mul_q.size() > 0) chk("timeout_latency", err_cyc - mul_q[0], 17);
        tick(3);
        chk("timeout_single_issue", mul_q.size(), 1);
        chk("timeout_no_out", ovr_q.size(), 0);
        send_job({8'd80, 8'd60, 8'd40, 8'd20}, {9'd100, 9'd50, 9'd50, 9'd56});
        drain();

        // Reset while waiting for the third product
        clear_logs();
        send_job({8'd1, 8'd2, 8'd3, 8'd4}, {9'd64, 9'd64, 9'd64, 9'd64});
        n = 0;
        while (mul_q.size() < 3 && n < 50) begin tick(); n++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_pix_out", int'(pix_out), 0);
        chk("mid_rst_mul_p", int'(mul_p), 0);
        chk("mid_rst_mul_l", int'(mul_l), 0);
        chk("mid_rst_mul_rdy", int'(mul_rdy), 0);
        chk("mid_rst_err", int'(err_timeout), 0);
        tick(5);
        chk("stray_out_valid", int'(out_valid), 0);
        chk("stray_in_ready", int'(in_ready), 1);
        send_job({8'd77, 8'd66, 8'd55, 8'd44}, {9'd32, 9'd96, 9'd64, 9'd64});
        drain();

        // Randomized jobs with random latency and backpressure
        rnd_lat = 1; rnd_ready = 1;
        for (int j = 0; j < 30; j++)
            send_job($urandom, {9'($urandom_range(0, 256)), 9'($urandom_range(0, 256)),
                                9'($urandom_range(0, 256)), 9'($urandom_range(0, 256))});
        drain();
        rnd_ready = 0;

        chk("protocol_violations", proto_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
